mux2way_arbiter: RTL and testbench
==================================

// Module: mux2way_arbiter
// PURPOSE
//  Round-robin burst arbiter sharing one 8-bit datapath between two requesters.
//  Drives the address of a 2-way 8-bit mux (sel) and registers the selected beat
//  into a valid/ready output stage.
//  Grant is held for a whole burst, ending on last or on a beat-count limit.
//  Sits between two producer ports (e.g. fetch/load sources) and one consumer.
// PARAMETERS
//  MAX_BEATS  16  max beats per grant before forced release; 0 = unlimited
//  CNT_W      5   beat counter width; must hold MAX_BEATS
// PORTS
//  clk        in   1  clock; all state changes on rising edge
//  reset      in   1  synchronous, active-high reset
//  req0       in   1  requester 0 has a beat on data0
//  data0      in   8  requester 0 beat
//  last0      in   1  beat on data0 ends its burst
//  ack0       out  1  beat of requester 0 accepted this cycle (combinational)
//  req1       in   1  requester 1 has a beat on data1
//  data1      in   8  requester 1 beat
//  last1      in   1  beat on data1 ends its burst
//  ack1       out  1  beat of requester 1 accepted this cycle (combinational)
//  sel        out  1  mux address: 0 -> data0, 1 -> data1 (registered)
//  out_valid  out  1  output register holds a beat
//  out_data   out  8  registered beat
//  out_last   out  1  registered copy of lastX of that beat
//  out_ready  in   1  consumer takes beat when out_valid & out_ready
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, sel=0, prio=0, cnt=0, out_valid=0, out_data=0, out_last=0.
//  Reset wins over all other events; a burst in flight is dropped, no ack.
//  States: IDLE, OWN0, OWN1. sel=1 iff state==OWN1; in IDLE sel holds.
//  IDLE: only reqX -> OWNX; both -> OWN[prio]; none -> IDLE. Takes 1 cycle;
//   no ack in IDLE.
//  space = !out_valid | out_ready. In OWNX: ackX = reqX & space; ack of the other
//   requester is always 0.
//  On ackX: out_data<=dataX, out_last<=lastX, out_valid<=1, cnt<=cnt+1.
//  No ack and out_ready & out_valid: out_valid<=0; data/last hold.
//  Release: on ackX with lastX=1, or cnt==MAX_BEATS-1 (MAX_BEATS!=0):
//   prio<=~X, cnt<=0; next = OWN(~X) if req(~X) this cycle, else IDLE.
//   Back-to-back switch costs no idle cycle.
//  Forced release does not modify out_last; the burst resumes on the next grant.
//  reqX low while OWNX: grant held (no timeout); cnt holds.
//  Throughput: 1 beat/cycle while out_ready=1; latency ackX -> out_valid = 1 cycle.
//  Unsent data may change while reqX=0; dataX/lastX must be stable while reqX=1
//   and ackX=0.
//  Consumer stall (out_ready=0, out_valid=1): ack=0, register holds, state holds.
// TESTING
//  Reset then req0=1, data0=8'hA5, last0=1, out_ready=1 -> cycle1 OWN0, sel=0;
//   ack0=1 cycle1; out_valid=1, out_data=A5, out_last=1 cycle2; state IDLE.
//  req0=req1=1 from IDLE after reset, 1-beat bursts -> grants alternate
//   0,1,0,1; sel toggles each beat; prio flips each release.
//  req1 3-beat burst 11,22,33 (last on 33), out_ready low 2 cycles mid-burst ->
//   out_data holds 22, ack1=0 during stall, then 33 with out_last=1.
//  MAX_BEATS=4, req0 with no last, req1=1 -> 4 beats of req0, then sel=1 with no
//   idle cycle; out_last=0 on the 4th beat.
//  reset asserted while OWN1 mid-burst -> next cycle state IDLE, out_valid=0,
//   sel=0, ack0=ack1=0.
//  req0 drops mid-burst for 3 cycles while req1=1 -> stays OWN0, ack1=0;
//   resumes on req0.

Source files
------------

// File: rtl/mux2way_arbiter.sv
// Round-robin burst arbiter: two producers share one 8-bit datapath feeding a
// registered valid/ready output stage. A grant lasts for a whole burst and ends
// on the producer's last beat or when the optional beat limit is reached.
module mux2way_arbiter #(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       last0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic       last1,
    output logic       ack1,
    output logic       sel,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam bit          LIMIT_EN = (MAX_BEATS != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        LIMIT_EN ? CNT_W'(MAX_BEATS - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                prio_q, prio_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;

    logic                space;
    logic                own1;
    logic                ack0_c, ack1_c;
    logic                accept;
    logic                beat_last;
    logic [DATA_W-1:0]   beat_data;
    logic                other_req;
    logic                limit_hit;

    // Next-state, grant/accept decode and output-stage update.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        ack0_c      = 1'b0;
        ack1_c      = 1'b0;

        space     = !out_valid_q || out_ready;
        own1      = (state_q == ST_OWN1);
        beat_last = own1 ? last1 : last0;
        beat_data = own1 ? data1 : data0;
        other_req = own1 ? req0 : req1;
        limit_hit = LIMIT_EN && (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = prio_q ? ST_OWN1 : ST_OWN0;
                end else if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: ack0_c = req0 && space && !reset;
            ST_OWN1: ack1_c = req1 && space && !reset;
            default: state_d = ST_IDLE;
        endcase

        accept = ack0_c || ack1_c;

        if (accept) begin
            out_data_d  = beat_data;
            out_last_d  = beat_last;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
            // Burst end or forced release hands priority to the other side.
            if (beat_last || limit_hit) begin
                prio_d = !own1;
                cnt_d  = '0;
                if (other_req) begin
                    state_d = own1 ? ST_OWN0 : ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Mux address follows the owner and holds its last value while idle.
        if (state_d != ST_IDLE) begin
            sel_d = (state_d == ST_OWN1);
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign ack0      = ack0_c;
    assign ack1      = ack1_c;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux2way_arbiter.sv
// Directed bench for mux2way_arbiter (beat limit set to 4).
module tb_mux2way_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, last0, ack0;
    logic       req1, last1, ack1;
    logic [7:0] data0, data1;
    logic       sel, out_valid, out_last, out_ready, busy;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;

    mux2way_arbiter #(.MAX_BEATS(4), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .last0     (last0),
        .ack0      (ack0),
        .req1      (req1),
        .data1     (data1),
        .last1     (last1),
        .ack1      (ack1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; out_ready = 1'b1;

        // Single one-beat burst from requester 0.
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_last", 32'(out_last), 32'd0);
        reset = 1'b0; req0 = 1'b1; data0 = 8'hA5; last0 = 1'b1;
        #1;
        check("t1_idle_ack0", 32'(ack0), 32'd0);
        tick();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_sel", 32'(sel), 32'd0);
        check("t1_ack0", 32'(ack0), 32'd1);
        check("t1_ack1", 32'(ack1), 32'd0);
        tick();
        req0 = 1'b0;
        #1;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'hA5);
        check("t1_last", 32'(out_last), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);
        tick();
        check("t1_drain", 32'(out_valid), 32'd0);
        check("t1_hold", 32'(out_data), 32'hA5);

        // Both requesting one-beat bursts: grants alternate.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
        data0 = 8'h01; data1 = 8'h02;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t2_sel", 32'(sel), (k % 2 == 1) ? 32'd1 : 32'd0);
            check("t2_ack0", 32'(ack0), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_ack1", 32'(ack1), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) check("t2_data", 32'(out_data), (k % 2 == 1) ? 32'h01 : 32'h02);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;

        // Requester 1 burst with a two-cycle consumer stall.
        do_reset();
        req1 = 1'b1; data1 = 8'h11; last1 = 1'b0;
        tick();
        check("t3_sel", 32'(sel), 32'd1);
        check("t3_ack_a", 32'(ack1), 32'd1);
        tick();
        data1 = 8'h22;
        #1;
        check("t3_ack_b", 32'(ack1), 32'd1);
        check("t3_data_a", 32'(out_data), 32'h11);
        tick();
        data1 = 8'h33; last1 = 1'b1; out_ready = 1'b0;
        #1;
        check("t3_stall_ack", 32'(ack1), 32'd0);
        check("t3_stall_data", 32'(out_data), 32'h22);
        check("t3_stall_valid", 32'(out_valid), 32'd1);
        tick();
        check("t3_stall2_ack", 32'(ack1), 32'd0);
        check("t3_stall2_data", 32'(out_data), 32'h22);
        check("t3_stall2_busy", 32'(busy), 32'd1);
        tick();
        out_ready = 1'b1;
        #1;
        check("t3_ack_c", 32'(ack1), 32'd1);
        tick();
        req1 = 1'b0;
        #1;
        check("t3_data_c", 32'(out_data), 32'h33);
        check("t3_last_c", 32'(out_last), 32'd1);
        check("t3_end_idle", 32'(busy), 32'd0);

        // Beat-limit forced release hands over with no idle cycle.
        do_reset();
        req0 = 1'b1; last0 = 1'b0; req1 = 1'b1; last1 = 1'b0;
        data0 = 8'h40; data1 = 8'h77;
        tick();
        for (int i = 0; i < 4; i++) begin
            data0 = 8'(8'h40 + i);
            #1;
            check("t4_ack0", 32'(ack0), 32'd1);
            check("t4_ack1", 32'(ack1), 32'd0);
            tick();
        end
        check("t4_sel", 32'(sel), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_data", 32'(out_data), 32'h43);
        check("t4_last", 32'(out_last), 32'd0);
        check("t4_ack1_next", 32'(ack1), 32'd1);
        check("t4_ack0_next", 32'(ack0), 32'd0);

        // Reset while requester 1 owns the datapath mid-burst.
        tick();
        check("t5_valid_pre", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_ack1", 32'(ack1), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_sel", 32'(sel), 32'd0);
        check("t5_ack0", 32'(ack0), 32'd0);
        check("t5_ack1", 32'(ack1), 32'd0);

        // Requester 0 pauses mid-burst; grant is held.
        do_reset();
        req0 = 1'b1; last0 = 1'b0; data0 = 8'h61;
        req1 = 1'b1; last1 = 1'b1; data1 = 8'h99;
        tick();
        check("t6_ack0_a", 32'(ack0), 32'd1);
        tick();
        req0 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("t6_gap_ack0", 32'(ack0), 32'd0);
            check("t6_gap_ack1", 32'(ack1), 32'd0);
            check("t6_gap_sel", 32'(sel), 32'd0);
            check("t6_gap_busy", 32'(busy), 32'd1);
            tick();
        end
        req0 = 1'b1; last0 = 1'b1; data0 = 8'h62;
        #1;
        check("t6_resume_ack0", 32'(ack0), 32'd1);
        check("t6_held_data", 32'(out_data), 32'h61);
        tick();
        req0 = 1'b0;
        #1;
        check("t6_sel", 32'(sel), 32'd1);
        check("t6_ack1", 32'(ack1), 32'd1);
        check("t6_data", 32'(out_data), 32'h62);
        check("t6_last", 32'(out_last), 32'd1);
        req1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
